// File: rtl/k005297_pkg.sv
// Shared CRC14 definitions (x^14+x^5+x^4+1, zero preset) and the page serializer state encoding.
package k005297_pkg;

    localparam int CRC14_W = 14;
    localparam logic [CRC14_W-1:0] CRC14_POLY = 14'h0031;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_CRC,
        ST_DONE
    } state_t;

    // One serial step: feedback is the outgoing MSB xor the incoming bit.
    function automatic logic [CRC14_W-1:0] crc14_step(input logic [CRC14_W-1:0] crc,
                                                      input logic din);
        logic fb;
        fb = crc[CRC14_W-1] ^ din;
        crc14_step = {crc[CRC14_W-2:0], 1'b0} ^ (fb ? CRC14_POLY : '0);
    endfunction

endpackage

// File: rtl/k005297_crc14gen_if.sv
// Page serializer bus: enable, page control, serial data in, serial data/CRC out.
// o_SELFCHK_ERR exists only when K005297_CRC14GEN_SELFCHECK_EN is defined.
interface k005297_crc14gen_if;
    import k005297_pkg::*;

    logic               i_CLK2M_PCEN_n;
    logic               i_PAGE_START;
    logic               i_ABORT;
    logic               i_BIT_STB;
    logic               i_DIN;
    logic               o_BDO;
    logic               o_BDO_VALID;
    logic               o_CRC_PHASE;
    logic               o_BUSY_n;
    logic               o_DONE;
    logic [CRC14_W-1:0] o_CRC;
`ifdef K005297_CRC14GEN_SELFCHECK_EN
    logic               o_SELFCHK_ERR;

    modport master (
        output i_CLK2M_PCEN_n, i_PAGE_START, i_ABORT, i_BIT_STB, i_DIN,
        input  o_BDO, o_BDO_VALID, o_CRC_PHASE, o_BUSY_n, o_DONE, o_CRC, o_SELFCHK_ERR
    );
    modport slave (
        input  i_CLK2M_PCEN_n, i_PAGE_START, i_ABORT, i_BIT_STB, i_DIN,
        output o_BDO, o_BDO_VALID, o_CRC_PHASE, o_BUSY_n, o_DONE, o_CRC, o_SELFCHK_ERR
    );
`else
    modport master (
        output i_CLK2M_PCEN_n, i_PAGE_START, i_ABORT, i_BIT_STB, i_DIN,
        input  o_BDO, o_BDO_VALID, o_CRC_PHASE, o_BUSY_n, o_DONE, o_CRC
    );
    modport slave (
        input  i_CLK2M_PCEN_n, i_PAGE_START, i_ABORT, i_BIT_STB, i_DIN,
        output o_BDO, o_BDO_VALID, o_CRC_PHASE, o_BUSY_n, o_DONE, o_CRC
    );
`endif
endinterface

// File: rtl/k005297_crc14_lfsr.sv
// Serial CRC14 register: clear wins over step; holds when neither is asserted.
module k005297_crc14_lfsr
    import k005297_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic               clear,
    input  logic               din,
    output logic [CRC14_W-1:0] crc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            crc <= '0;
        else if (step)
            crc <= crc14_step(crc, din);
    end

endmodule

// File: rtl/k005297_crc14gen.sv
// Serializes one bubble page then its CRC14 MSB first; outputs registered, one tick latency.
// Advances only on enable ticks with a bit strobe; optional checker via K005297_CRC14GEN_SELFCHECK_EN.
module k005297_crc14gen
    import k005297_pkg::*;
#(
    parameter int PAGE_BITS = 512,
    parameter int CNT_W     = 12
)(
    input  logic              i_MCLK,
    input  logic              i_SYS_RST_n,
    k005297_crc14gen_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(PAGE_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(CRC14_W - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               bdo, bdo_nxt, bdo_vld, vld_nxt, phase, phase_nxt;
    logic               busy_n, busy_n_nxt, done, done_nxt;
    logic               tick, stb, abort, start;
    logic               crc_step, crc_clr, crc_din;
    logic [CRC14_W-1:0] crc;

    assign tick  = !bus.i_CLK2M_PCEN_n;
    assign stb   = bus.i_BIT_STB;
    assign abort = bus.i_ABORT && (state != ST_IDLE);
    assign start = bus.i_PAGE_START && (state == ST_IDLE);

    always_ff @(posedge i_MCLK) begin
        if (!i_SYS_RST_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bdo     <= 1'b0;
            bdo_vld <= 1'b0;
            phase   <= 1'b0;
            busy_n  <= 1'b1;
            done    <= 1'b0;
        end else if (tick) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bdo     <= bdo_nxt;
            bdo_vld <= vld_nxt;
            phase   <= phase_nxt;
            busy_n  <= busy_n_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (bus.i_PAGE_START)      state_nxt = ST_DATA;
                ST_DATA: if (stb && cnt == LAST_DATA) state_nxt = ST_CRC;
                ST_CRC:  if (stb && cnt == LAST_CRC)  state_nxt = ST_DONE;
                default:                             state_nxt = ST_IDLE;
            endcase
        end
    end

    // In the CRC phase, stepping with din=crc[13] zeroes the feedback, giving a plain shift.
    always_comb begin
        cnt_nxt    = cnt;
        bdo_nxt    = bdo;
        vld_nxt    = 1'b0;
        phase_nxt  = phase;
        busy_n_nxt = busy_n;
        done_nxt   = 1'b0;
        crc_clr    = 1'b0;
        crc_step   = 1'b0;
        crc_din    = bus.i_DIN;
        if (abort) begin
            cnt_nxt    = '0;
            bdo_nxt    = 1'b0;
            phase_nxt  = 1'b0;
            busy_n_nxt = 1'b1;
            crc_clr    = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    busy_n_nxt = !bus.i_PAGE_START;
                    if (bus.i_PAGE_START) begin
                        cnt_nxt = '0;
                        crc_clr = 1'b1;
                    end
                end
                ST_DATA: if (stb) begin
                    bdo_nxt  = bus.i_DIN;
                    vld_nxt  = 1'b1;
                    crc_step = 1'b1;
                    cnt_nxt  = (cnt == LAST_DATA) ? '0 : cnt + CNT_W'(1);
                end
                ST_CRC: if (stb) begin
                    bdo_nxt   = crc[CRC14_W-1];
                    vld_nxt   = 1'b1;
                    phase_nxt = 1'b1;
                    crc_step  = 1'b1;
                    crc_din   = crc[CRC14_W-1];
                    cnt_nxt   = (cnt == LAST_CRC) ? '0 : cnt + CNT_W'(1);
                end
                default: begin
                    done_nxt  = 1'b1;
                    phase_nxt = 1'b0;
                end
            endcase
        end
    end

    k005297_crc14_lfsr u_gen (
        .clk   (i_MCLK),
        .rst_n (i_SYS_RST_n),
        .step  (tick && crc_step),
        .clear (tick && crc_clr),
        .din   (crc_din),
        .crc   (crc)
    );

`ifdef K005297_CRC14GEN_SELFCHECK_EN
    logic [CRC14_W-1:0] chk;
    logic               chk_err;

    k005297_crc14_lfsr u_chk (
        .clk   (i_MCLK),
        .rst_n (i_SYS_RST_n),
        .step  (tick && bdo_vld),
        .clear (tick && start),
        .din   (bdo),
        .crc   (chk)
    );

    // The final CRC bit is folded in on this same tick, so judge the stepped value.
    always_ff @(posedge i_MCLK) begin
        if (!i_SYS_RST_n)
            chk_err <= 1'b0;
        else if (tick && start)
            chk_err <= 1'b0;
        else if (tick && state == ST_DONE && !abort)
            chk_err <= ((bdo_vld ? crc14_step(chk, bdo) : chk) != '0);
    end

    assign bus.o_SELFCHK_ERR = chk_err;
`endif

    assign bus.o_BDO       = bdo;
    assign bus.o_BDO_VALID = bdo_vld;
    assign bus.o_CRC_PHASE = phase;
    assign bus.o_BUSY_n    = busy_n;
    assign bus.o_DONE      = done;
    assign bus.o_CRC       = crc;

endmodule

// File: doc/k005297_crc14gen.md
Name: k005297_crc14gen

Overview:
- Write-direction counterpart of the Z14 evaluator: it serializes one bubble page and appends the CRC14 check word that the evaluator later verifies on readback.
- It accepts the page's data bits one per bit strobe and outputs each bit.
- It accumulates CRC14 (polynomial x^14+x^5+x^4+1, zero preset) as the bits pass through.
- After the last data bit it emits the 14 CRC bits, MSB first, on the same serial output.
- Sits between the page buffer/mask logic and the bubble data output mux.

Parameters:
- PAGE_BITS, 512: number of data bits per page before the CRC is appended; legal range 1..4095.
- CNT_W, 12: width of the bit counter; must satisfy 2^CNT_W > PAGE_BITS.

Ports:
- i_MCLK  in  1  master clock
- i_SYS_RST_n  in  1  synchronous active-low reset
- i_CLK2M_PCEN_n  in  1  clock enable, active-low; all state advances only when low
- i_PAGE_START  in  1  begin a page (sampled on an enable tick)
- i_ABORT  in  1  abandon the current page
- i_BIT_STB  in  1  one serial bit slot (qualified by the enable)
- i_DIN  in  1  data bit for the current slot
- o_BDO  out  1  serial output bit (data, then CRC)
- o_BDO_VALID  out  1  o_BDO carries a page/CRC bit
- o_CRC_PHASE  out  1  high while the CRC bits are being emitted
- o_BUSY_n  out  1  low from accepted start until DONE clears
- o_DONE  out  1  one-tick pulse after the last CRC bit
- o_CRC  out  14  running CRC register

Behaviour:
- Tick: any i_MCLK edge with i_CLK2M_PCEN_n=0. Reset is checked on every i_MCLK edge, regardless of the enable.
- Reset (i_SYS_RST_n=0): state IDLE, crc=0, cnt=0, o_BDO=0, o_BDO_VALID=0, o_CRC_PHASE=0, o_BUSY_n=1, o_DONE=0.
- States: IDLE, DATA, CRC, DONE.
- IDLE:
  - i_PAGE_START on a tick: crc<=0, cnt<=0, go to DATA, o_BUSY_n<=0.
  - i_BIT_STB is ignored.
- DATA, on a tick with i_BIT_STB:
  - o_BDO<=i_DIN and o_BDO_VALID<=1. The output is registered, so latency is one tick.
  - fb=crc[13]^i_DIN.
  - crc<={crc[12:6], crc[5]... } is wrong; the exact update is: new[0]=fb, new[3:1]=old[2:0], new[4]=old[3]^fb, new[5]=old[4]^fb, new[13:6]=old[12:5].
  - cnt<=cnt+1. When cnt==PAGE_BITS-1, go to CRC with cnt<=0.
- DATA/CRC, tick without i_BIT_STB: o_BDO_VALID<=0; o_BDO, crc and cnt hold.
- CRC, on a tick with i_BIT_STB:
  - o_BDO<=crc[13], o_BDO_VALID<=1, o_CRC_PHASE<=1.
  - crc<={crc[12:0],1'b0}.
  - cnt<=cnt+1. At cnt==13, go to DONE.
- DONE (one tick):
  - o_DONE=1, o_BDO_VALID=0, o_CRC_PHASE=0.
  - Next tick: IDLE, o_BUSY_n=1.
  - crc is 0 here and stays 0 in IDLE.
- i_PAGE_START outside IDLE is ignored; no restart.
- i_ABORT on a tick in any non-IDLE state:
  - Go to IDLE, crc<=0, all outputs go to their reset values, and no o_DONE is produced.
  - i_ABORT has priority over i_BIT_STB and i_PAGE_START.
- Enable high: everything holds, including the o_DONE level. The DONE state lasts exactly one tick, not one i_MCLK cycle.
- After the full page plus CRC stream, feeding it into the Z14 evaluator gives an all-zero register (Z14_n=0).

Optional Feature:
- Macro: K005297_CRC14GEN_SELFCHECK_EN.
- When defined, adds an independent checker CRC register that runs the same polynomial over every emitted o_BDO bit (data and CRC) while o_BDO_VALID=1.
- The checker clears at page start.
- On the DONE tick, output o_SELFCHK_ERR (1 bit) is set to 1 if the checker is nonzero. It stays set until the next accepted start or reset.
- When undefined: no checker and no o_SELFCHK_ERR port; behaviour is otherwise identical.

Decomposition:
- Shared package k005297_pkg holds:
  - CRC14_POLY=14'h0031 (taps 5, 4, 0, with the x^14 term implicit)
  - CRC14_W=14
  - state enum {ST_IDLE, ST_DATA, ST_CRC, ST_DONE}
  - a crc14_step(crc, bit) function
- One natural sub-module, k005297_crc14_lfsr (step, clear, din, crc), is instantiated once for the generator and once for the self-check.

Test Plan:
- All-zero page (PAGE_BITS=512, i_DIN=0) -> o_CRC=0 after the data; 14 CRC bits all 0; o_DONE pulses once, exactly 1 tick after the 526th valid bit.
- Single 1 as the last data bit, all others 0 -> o_CRC=14'h0031 entering CRC; emitted CRC bits MSB first are 00000000110001.
- Random page replayed into a reference CRC14 model over data+CRC -> residue 0. With SELFCHECK_EN, o_SELFCHK_ERR=0; a forced CRC-bit flip gives o_SELFCHK_ERR=1.
- Enable gaps: i_CLK2M_PCEN_n high for 3 cycles mid-page, and i_BIT_STB idle on some ticks -> identical bit stream, and cnt/crc frozen during the gaps.
- i_ABORT at data bit 100, then i_PAGE_START -> no o_DONE; the new page CRC matches the from-zero value.
- Reset asserted mid-CRC phase, and i_PAGE_START while busy -> reset values on the next i_MCLK edge; the busy-time start is ignored (cnt continues).
